fetch_sequencer: RTL and testbench

Controller for the instruction-fetch stage of the five-stage MIPS pipeline. It owns the PC register, drives the instruction-memory request handshake, and generates the IF/ID register write-enable and flush. It reconciles variable-latency instruction memory with load-use stalls from hazard detection and branch/jump redirects resolved in ID, so the IF/ID register sees exactly one write per fetched, non-squashed instruction.

---
 rtl/fetch_sequencer_pkg.sv | 6 +
 rtl/fetch_if.sv | 23 ++
 rtl/fetch_hold_buf.sv | 12 +
 rtl/fetch_sequencer.sv | 82 ++++++++
 tb/tb_fetch_sequencer.sv | 102 ++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared IF-stage types and constants
package fetch_sequencer_pkg;
  typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: imem handshake, hazard/redirect inputs and IF/ID outputs of the fetch stage
interface fetch_if;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_ready;
  logic [31:0] imem_rdata;
  logic stall;
  logic redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] ifid_inst;
  logic ifid_write;
  logic ifid_flush;
  modport master (
    output imem_req, imem_addr, pc, pc_plus4, ifid_inst, ifid_write, ifid_flush,
    input imem_ready, imem_rdata, stall, redirect, redirect_pc
  );
  modport slave (
    input imem_req, imem_addr, pc, pc_plus4, ifid_inst, ifid_write, ifid_flush,
    output imem_ready, imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: 32-bit single-entry register with load enable
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (load) q <= d;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and imem/IF-ID sequencing for the MIPS fetch stage
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic    clk,
  input logic    rst,
  fetch_if.master f
);
  state_t state, state_n;
  logic [31:0] pc, pc_n, tgt, buf_q, pend_q;
  logic buf_ld, pend_ld;
  assign tgt = {f.redirect_pc[31:2], 2'b00};
  assign f.pc = pc;
  assign f.imem_addr = pc;
  assign f.pc_plus4 = pc + 32'd4;
  always_ff @(posedge clk)
    if (rst) begin
      state <= BOOT;
      pc <= RESET_PC;
    end else begin
      state <= state_n;
      pc <= pc_n;
    end
  always_comb begin
    state_n = state;
    pc_n = pc;
    buf_ld = 1'b0;
    pend_ld = 1'b0;
    f.imem_req = 1'b0;
    f.ifid_write = 1'b0;
    f.ifid_flush = 1'b0;
    f.ifid_inst = NOP;
    case (state)
      BOOT: begin
        f.ifid_flush = 1'b1;
        state_n = FETCH;
      end
      FETCH: begin
        f.imem_req = 1'b1;
        f.ifid_inst = f.imem_rdata;
        if (f.redirect) begin
          f.ifid_flush = 1'b1;
          pend_ld = !f.imem_ready;
          pc_n = f.imem_ready ? tgt : pc;
          state_n = f.imem_ready ? FETCH : DRAIN;
        end else if (f.imem_ready) begin
          buf_ld = f.stall;
          f.ifid_write = !f.stall;
          pc_n = f.stall ? pc : pc + 32'd4;
          state_n = f.stall ? HOLD : FETCH;
        end
      end
      HOLD: begin
        f.ifid_inst = buf_q;
        if (f.redirect) begin
          f.ifid_flush = 1'b1;
          pc_n = tgt;
          state_n = FETCH;
        end else if (!f.stall) begin
          f.ifid_write = 1'b1;
          pc_n = pc + 32'd4;
          state_n = FETCH;
        end
      end
      DRAIN: begin
        // old address stays on the bus; the returning data is squashed
        f.imem_req = 1'b1;
        f.ifid_flush = 1'b1;
        pend_ld = f.redirect;
        if (f.imem_ready) begin
          pc_n = f.redirect ? tgt : pend_q;
          state_n = FETCH;
        end
      end
      default: state_n = BOOT;
    endcase
  end
  fetch_hold_buf u_buf (.clk(clk), .rst(rst), .load(buf_ld), .d(f.imem_rdata), .q(buf_q));
  fetch_hold_buf u_pend (.clk(clk), .rst(rst), .load(pend_ld), .d(tgt), .q(pend_q));
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed per-cycle vectors with a queued scoreboard and negedge monitor
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int cyc_id = 0;
  typedef struct {
    int id;
    logic [31:0] pc;
    logic req, wr, fl;
    logic [31:0] inst;
    bit ichk;
  } exp_t;
  exp_t q[$];
  fetch_if f ();
  fetch_sequencer dut (.clk(clk), .rst(rst), .f(f));
  always #5 clk = ~clk;
  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, id, act, req);
    end
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("pc", e.id, f.pc, e.pc);
      check("imem_addr", e.id, f.imem_addr, e.pc);
      check("pc_plus4", e.id, f.pc_plus4, e.pc + 32'd4);
      check("imem_req", e.id, {31'b0, f.imem_req}, {31'b0, e.req});
      check("ifid_write", e.id, {31'b0, f.ifid_write}, {31'b0, e.wr});
      check("ifid_flush", e.id, {31'b0, f.ifid_flush}, {31'b0, e.fl});
      if (e.ichk) check("ifid_inst", e.id, f.ifid_inst, e.inst);
    end
  task automatic cyc(input bit r, input bit rdy, input logic [31:0] rdata, input bit st,
                     input bit rd, input logic [31:0] rpc, input logic [31:0] e_pc,
                     input bit e_req, input bit e_wr, input bit e_fl, input bit e_ichk,
                     input logic [31:0] e_inst);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    f.imem_ready = rdy;
    f.imem_rdata = rdata;
    f.stall = st;
    f.redirect = rd;
    f.redirect_pc = rpc;
    e.id = cyc_id;
    e.pc = e_pc;
    e.req = e_req;
    e.wr = e_wr;
    e.fl = e_fl;
    e.ichk = e_ichk;
    e.inst = e_inst;
    q.push_back(e);
    cyc_id++;
  endtask
  initial begin
    f.imem_ready = 1'b0;
    f.imem_rdata = '0;
    f.stall = 1'b0;
    f.redirect = 1'b0;
    f.redirect_pc = '0;
    repeat (2) @(posedge clk);
    cyc(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 1, 1, 32'h0);
    cyc(0, 1, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 1, 1, 32'h0);
    cyc(0, 1, 32'h2001_0001, 0, 0, 32'h0, 32'h0, 1, 1, 0, 1, 32'h2001_0001);
    cyc(0, 1, 32'h2002_0002, 0, 0, 32'h0, 32'h4, 1, 1, 0, 1, 32'h2002_0002);
    cyc(0, 1, 32'h8C22_0000, 1, 0, 32'h0, 32'h8, 1, 0, 0, 0, 32'h0);
    cyc(0, 1, 32'hDEAD_BEEF, 1, 0, 32'h0, 32'h8, 0, 0, 0, 1, 32'h8C22_0000);
    cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h8, 0, 1, 0, 1, 32'h8C22_0000);
    cyc(0, 1, 32'h1111_1111, 0, 1, 32'h40, 32'hC, 1, 0, 1, 0, 32'h0);
    cyc(0, 1, 32'h2222_2222, 0, 0, 32'h0, 32'h40, 1, 1, 0, 1, 32'h2222_2222);
    cyc(0, 1, 32'h3333_3333, 0, 1, 32'h12, 32'h44, 1, 0, 1, 0, 32'h0);
    cyc(0, 0, 32'h0, 0, 1, 32'h100, 32'h10, 1, 0, 1, 0, 32'h0);
    cyc(0, 0, 32'h0, 0, 1, 32'h200, 32'h10, 1, 0, 1, 0, 32'h0);
    cyc(0, 0, 32'h0, 0, 0, 32'h0, 32'h10, 1, 0, 1, 0, 32'h0);
    cyc(0, 1, 32'h4444_4444, 0, 0, 32'h0, 32'h10, 1, 0, 1, 0, 32'h0);
    cyc(0, 1, 32'h5555_5555, 1, 0, 32'h0, 32'h200, 1, 0, 0, 0, 32'h0);
    cyc(0, 0, 32'h0, 1, 1, 32'h80, 32'h200, 0, 0, 1, 0, 32'h0);
    cyc(0, 1, 32'h6666_6666, 0, 0, 32'h0, 32'h80, 1, 1, 0, 1, 32'h6666_6666);
    cyc(0, 0, 32'h0, 0, 1, 32'h300, 32'h84, 1, 0, 1, 0, 32'h0);
    cyc(1, 0, 32'h0, 0, 0, 32'h0, 32'h84, 1, 0, 1, 0, 32'h0);
    cyc(0, 1, 32'h7777_7777, 0, 0, 32'h0, 32'h0, 0, 0, 1, 1, 32'h0);
    cyc(0, 1, 32'h8888_8888, 0, 1, 32'hFFFF_FFFC, 32'h0, 1, 0, 1, 0, 32'h0);
    cyc(0, 1, 32'h9999_9999, 0, 0, 32'h0, 32'hFFFF_FFFC, 1, 1, 0, 1, 32'h9999_9999);
    cyc(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 32'h0);
    cyc(0, 1, 32'hAAAA_AAAA, 0, 0, 32'h0, 32'h0, 1, 1, 0, 1, 32'hAAAA_AAAA);
    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
